// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline types for the M-stage memory controller.
// State encoding, result-select code and default timeout.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } mctl_state_t;

  localparam logic [1:0] RESULTSRC_MEM = 2'b01;

  localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// Data-memory bus: req/gnt/rvalid handshake.
// master = pipeline controller, slave = memory.
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              dmem_gnt;
  logic              dmem_rvalid;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_err;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_gnt,
    input  dmem_rvalid,
    input  dmem_rdata,
    input  dmem_err
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_gnt,
    output dmem_rvalid,
    output dmem_rdata,
    output dmem_err
  );

endinterface

// File: rtl/mem_stage_ctrl_timeout_ctr.sv
// Cycle counter bounding time spent in REQ+WAIT.
// expired fires during the TIMEOUT-th enabled cycle.
import pipe_pkg::*;

module mem_timeout_ctr #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic expired
);

  logic [15:0] cnt;

  // clear on entry to REQ, count while busy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      unique case (1'b1)
        clear:   cnt <= '0;
        en:      cnt <= cnt + 16'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign expired = en && (cnt == 16'(TIMEOUT - 1));

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage data-memory sequencer: issues bus accesses,
// freezes the pipe until done, captures load data/faults.
import pipe_pkg::*;

module mem_stage_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              memwriteM,
  input  logic [1:0]        resultsrcM,
  input  logic [ADDR_W-1:0] aluresultM,
  input  logic [DATA_W-1:0] writedataM,
  mem_stage_ctrl_if.master  dmem,
  output logic              stall_m,
  output logic              flush_w,
  output logic [DATA_W-1:0] readdataM,
  output logic              bus_fault,
  output logic [ADDR_W-1:0] fault_addr
);

  mctl_state_t state;
  logic access;
  logic resp;
  logic tmo;
  logic fin;
  logic fault_ev;
  logic expired;

  assign access = memwriteM | (resultsrcM == RESULTSRC_MEM);

  // a response beats an expiry landing in the same cycle
  assign resp = dmem.dmem_rvalid
              & (((state == REQ) & dmem.dmem_gnt)
                 | (state == WAIT));
  assign tmo      = expired & ~resp;
  assign fin      = resp | tmo;
  assign fault_ev = (resp & dmem.dmem_err) | tmo;

  assign stall_m = reset_n
                 & (((state == IDLE) & access)
                    | (state == REQ)
                    | (state == WAIT));
  assign flush_w = stall_m;

  mem_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_ctr (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  ((state == IDLE) & access),
    .en     ((state == REQ) | (state == WAIT)),
    .expired(expired)
  );

  // bus sequencing FSM with registered request outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      dmem.dmem_req   <= 1'b0;
      dmem.dmem_we    <= 1'b0;
      dmem.dmem_addr  <= '0;
      dmem.dmem_wdata <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (access) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= memwriteM;
            dmem.dmem_addr  <= aluresultM;
            dmem.dmem_wdata <= writedataM;
            state           <= REQ;
          end
        end
        REQ: begin
          if (fin) begin
            dmem.dmem_req <= 1'b0;
            state         <= DONE;
          end else if (dmem.dmem_gnt) begin
            dmem.dmem_req <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (fin) begin
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // completion: load data and sticky first-fault capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdataM  <= '0;
      bus_fault  <= 1'b0;
      fault_addr <= '0;
    end else begin
      if (fin && !dmem.dmem_we) begin
        readdataM <= fault_ev ? '0 : dmem.dmem_rdata;
      end
      if (fault_ev) begin
        bus_fault <= 1'b1;
        if (!bus_fault) begin
          fault_addr <= dmem.dmem_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Randomized bench for mem_stage_ctrl with a
// transaction-level reference model.
module tb_mem_stage_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        memwriteM;
  logic [1:0]  resultsrcM;
  logic [31:0] aluresultM;
  logic [31:0] writedataM;
  logic        stall_m;
  logic        flush_w;
  logic [31:0] readdataM;
  logic        bus_fault;
  logic [31:0] fault_addr;

  int total = 0;
  int bad = 0;

  logic [31:0] m_rd;
  logic        m_fault;
  logic [31:0] m_faddr;

  mem_stage_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_stage_ctrl #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .memwriteM (memwriteM),
    .resultsrcM(resultsrcM),
    .aluresultM(aluresultM),
    .writedataM(writedataM),
    .dmem      (bus.master),
    .stall_m   (stall_m),
    .flush_w   (flush_w),
    .readdataM (readdataM),
    .bus_fault (bus_fault),
    .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic slave_idle();
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_err    = 1'b0;
    bus.dmem_rdata  = 32'h0;
  endtask

  task automatic m_reset();
    m_rd    = 32'h0;
    m_fault = 1'b0;
    m_faddr = 32'h0;
  endtask

  // transaction-level expectation: g = grant cycle (0 never),
  // d = response delay after grant
  task automatic model(input bit st, input logic [1:0] rs,
                       input logic [31:0] a, input int g,
                       input int d, input bit e,
                       input logic [31:0] rdv,
                       output int exp_stall);
    int  busy;
    bit  to;
    bit  f;
    busy = (g == 0) ? 1000 : g + d;
    to   = busy > TMO;
    if (to) busy = TMO;
    exp_stall = 1 + busy;
    f = to || e;
    if (!st && rs == 2'b01) m_rd = f ? 32'h0 : rdv;
    if (f) begin
      if (!m_fault) m_faddr = a;
      m_fault = 1'b1;
    end
  endtask

  // drives one access starting at edge+1 in IDLE; returns at
  // edge+1 of the following IDLE cycle
  task automatic drive(input bit st, input logic [1:0] rs,
                       input logic [31:0] a, wd,
                       input int g, d, input bit e,
                       input logic [31:0] rdv,
                       output int stall_n, output bit stable_ok,
                       output bit flush_ok,
                       output logic [31:0] rd,
                       output logic bf,
                       output logic [31:0] fa);
    int rq;
    int after;
    bit granted;
    bit responded;
    memwriteM  = st;
    resultsrcM = rs;
    aluresultM = a;
    writedataM = wd;
    rq = 0; after = 0; granted = 0; responded = 0;
    stall_n = 0; stable_ok = 1; flush_ok = 1;
    for (int c = 0; c < 64; c++) begin
      #1;
      slave_idle();
      bus.dmem_rdata = $urandom;
      if (granted) after++;
      if (bus.dmem_req && !granted) begin
        rq++;
        if (bus.dmem_addr !== a || bus.dmem_wdata !== wd
            || bus.dmem_we !== st)
          stable_ok = 0;
        if (rq == g) begin
          bus.dmem_gnt = 1'b1;
          granted = 1;
          after = 0;
        end
      end
      if (granted && !responded && after == d) begin
        bus.dmem_rvalid = 1'b1;
        bus.dmem_err    = e;
        bus.dmem_rdata  = rdv;
        responded = 1;
      end
      #1;
      if (flush_w !== stall_m) flush_ok = 0;
      if (stall_m === 1'b0) break;
      stall_n++;
      @(posedge clk);
      #1;
    end
    rd = readdataM;
    bf = bus_fault;
    fa = fault_addr;
    @(posedge clk);
    #1;
    slave_idle();
    memwriteM  = 1'b0;
    resultsrcM = 2'b00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    memwriteM = 1'b0;
    resultsrcM = 2'b00;
    aluresultM = 32'h0;
    writedataM = 32'h0;
    slave_idle();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    m_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    slave_idle();
    memwriteM  = 1'b1;
    resultsrcM = 2'b01;
    aluresultM = $urandom;
    writedataM = $urandom;
    @(posedge clk);
    #2;
    total++;
    if (stall_m !== 1'b0 || flush_w !== 1'b0) begin
      bad++;
      $display("FAIL reset_stall: got %b/%b want 0/0",
               stall_m, flush_w);
    end
    total++;
    if (bus.dmem_req !== 1'b0 || bus.dmem_we !== 1'b0
        || bus.dmem_addr !== 32'h0 || bus.dmem_wdata !== 32'h0) begin
      bad++;
      $display("FAIL reset_bus: got req=%b we=%b a=%h w=%h want zeros",
               bus.dmem_req, bus.dmem_we, bus.dmem_addr,
               bus.dmem_wdata);
    end
    total++;
    if (readdataM !== 32'h0 || bus_fault !== 1'b0
        || fault_addr !== 32'h0) begin
      bad++;
      $display("FAIL reset_regs: got rd=%h bf=%b fa=%h want zeros",
               readdataM, bus_fault, fault_addr);
    end
    do_reset();
  endtask

  task automatic test_load_basic();
    int sn, es;
    bit so, fo;
    logic [31:0] rd, fa;
    logic bf;
    model(0, 2'b01, 32'h100, 1, 0, 0, 32'hDEADBEEF, es);
    drive(0, 2'b01, 32'h100, 32'h0, 1, 0, 0, 32'hDEADBEEF,
          sn, so, fo, rd, bf, fa);
    total++;
    if (sn !== 2) begin
      bad++;
      $display("FAIL load_stall: got %0d want 2", sn);
    end
    total++;
    if (rd !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL load_data: got %h want deadbeef", rd);
    end
    total++;
    if (!fo || !so) begin
      bad++;
      $display("FAIL load_flush_stable: got %b/%b want 1/1", fo, so);
    end
  endtask

  task automatic test_store_delayed();
    int sn, es;
    bit so, fo;
    logic [31:0] rd, fa;
    logic bf;
    model(1, 2'b00, 32'h200, 4, 2, 0, 32'hAAAA5555, es);
    drive(1, 2'b00, 32'h200, 32'h12345678, 4, 2, 0, 32'hAAAA5555,
          sn, so, fo, rd, bf, fa);
    total++;
    if (sn !== 7) begin
      bad++;
      $display("FAIL store_stall: got %0d want 7", sn);
    end
    total++;
    if (!so) begin
      bad++;
      $display("FAIL store_stable: got %b want 1", so);
    end
    total++;
    if (rd !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL store_rd_kept: got %h want deadbeef", rd);
    end
  endtask

  task automatic test_back_to_back();
    int sn1, sn2, es;
    bit so, fo;
    logic [31:0] rd1, rd2, fa, v1, v2;
    logic bf;
    v1 = $urandom;
    v2 = $urandom;
    model(0, 2'b01, 32'h1000, 1, 0, 0, v1, es);
    drive(0, 2'b01, 32'h1000, 32'h0, 1, 0, 0, v1,
          sn1, so, fo, rd1, bf, fa);
    model(0, 2'b01, 32'h1004, 1, 0, 0, v2, es);
    drive(0, 2'b01, 32'h1004, 32'h0, 1, 0, 0, v2,
          sn2, so, fo, rd2, bf, fa);
    total++;
    if (sn1 !== 2 || sn2 !== 2) begin
      bad++;
      $display("FAIL b2b_stall: got %0d,%0d want 2,2", sn1, sn2);
    end
    total++;
    if (rd1 !== v1 || rd2 !== v2) begin
      bad++;
      $display("FAIL b2b_data: got %h,%h want %h,%h",
               rd1, rd2, v1, v2);
    end
  endtask

  task automatic test_timeout();
    int sn, es;
    bit so, fo;
    logic [31:0] rd, fa;
    logic bf;
    do_reset();
    model(0, 2'b01, 32'h80, 1, 0, 0, 32'h5A5A5A5A, es);
    drive(0, 2'b01, 32'h80, 32'h0, 1, 0, 0, 32'h5A5A5A5A,
          sn, so, fo, rd, bf, fa);
    model(0, 2'b01, 32'h300, 1, 100, 0, 32'h0, es);
    drive(0, 2'b01, 32'h300, 32'h0, 1, 100, 0, 32'h0,
          sn, so, fo, rd, bf, fa);
    total++;
    if (sn !== 1 + TMO) begin
      bad++;
      $display("FAIL tmo_stall: got %0d want %0d", sn, 1 + TMO);
    end
    total++;
    if (bf !== 1'b1 || fa !== 32'h300 || rd !== 32'h0) begin
      bad++;
      $display("FAIL tmo_fault: got bf=%b fa=%h rd=%h want 1 300 0",
               bf, fa, rd);
    end
    model(1, 2'b00, 32'h400, 1, 0, 1, 32'h0, es);
    drive(1, 2'b00, 32'h400, 32'h77, 1, 0, 1, 32'h0,
          sn, so, fo, rd, bf, fa);
    total++;
    if (bf !== 1'b1 || fa !== 32'h300) begin
      bad++;
      $display("FAIL err_first_wins: got bf=%b fa=%h want 1 300",
               bf, fa);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    memwriteM  = 1'b0;
    resultsrcM = 2'b01;
    aluresultM = 32'h500;
    writedataM = 32'h0;
    @(posedge clk);
    #1;
    total++;
    if (bus.dmem_req !== 1'b1) begin
      bad++;
      $display("FAIL mid_req_up: got %b want 1", bus.dmem_req);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (bus.dmem_req !== 1'b0 || stall_m !== 1'b0) begin
      bad++;
      $display("FAIL mid_req_async: got %b/%b want 0/0",
               bus.dmem_req, stall_m);
    end
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    bus.dmem_gnt = 1'b1;
    @(posedge clk);
    #1;
    bus.dmem_gnt = 1'b0;
    #1;
    total++;
    if (stall_m !== 1'b1 || bus.dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL mid_in_wait: got stall=%b req=%b want 1 0",
               stall_m, bus.dmem_req);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (stall_m !== 1'b0 || flush_w !== 1'b0
        || bus.dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL wait_reset: got %b/%b/%b want 0/0/0",
               stall_m, flush_w, bus.dmem_req);
    end
    memwriteM  = 1'b0;
    resultsrcM = 2'b00;
    #1 reset_n = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_err    = 1'b1;
    bus.dmem_rdata  = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    slave_idle();
    total++;
    if (readdataM !== m_rd || bus_fault !== m_fault
        || stall_m !== 1'b0 || bus.dmem_req !== 1'b0) begin
      bad++;
      $display("FAIL stray_rvalid: got rd=%h bf=%b st=%b rq=%b want %h %b 0 0",
               readdataM, bus_fault, stall_m, bus.dmem_req,
               m_rd, m_fault);
    end
  endtask

  task automatic test_non_mem();
    logic [1:0] rs;
    int errs;
    errs = 0;
    for (int i = 0; i < 8; i++) begin
      case ($urandom_range(0, 2))
        0:       rs = 2'b00;
        1:       rs = 2'b10;
        default: rs = 2'b11;
      endcase
      memwriteM  = 1'b0;
      resultsrcM = rs;
      aluresultM = $urandom;
      writedataM = $urandom;
      #1;
      if (stall_m !== 1'b0 || flush_w !== 1'b0) errs++;
      @(posedge clk);
      #1;
      if (bus.dmem_req !== 1'b0) errs++;
    end
    resultsrcM = 2'b00;
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL non_mem: got %0d bad cycles want 0", errs);
    end
  endtask

  task automatic test_random();
    int sn, es, g, d;
    bit st, e, so, fo;
    logic [1:0] rs;
    logic [31:0] a, wd, rdv, rd, fa;
    logic bf;
    for (int i = 0; i < 40; i++) begin
      st  = $urandom_range(0, 1);
      rs  = st ? 2'($urandom_range(0, 3)) : 2'b01;
      a   = $urandom;
      wd  = $urandom;
      rdv = $urandom;
      g   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      d   = $urandom_range(0, 4);
      e   = ($urandom_range(0, 7) == 0);
      model(st, rs, a, g, d, e, rdv, es);
      drive(st, rs, a, wd, g, d, e, rdv, sn, so, fo, rd, bf, fa);
      total++;
      if (sn !== es || !so || !fo) begin
        bad++;
        $display("FAIL rnd_seq[%0d]: got stall=%0d st=%b fl=%b want %0d 1 1",
                 i, sn, so, fo, es);
      end
      total++;
      if (rd !== m_rd || bf !== m_fault || fa !== m_faddr) begin
        bad++;
        $display("FAIL rnd_res[%0d]: got rd=%h bf=%b fa=%h want %h %b %h",
                 i, rd, bf, fa, m_rd, m_fault, m_faddr);
      end
      if ($urandom_range(0, 2) == 0) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_store_delayed();
    test_back_to_back();
    test_non_mem();
    test_timeout();
    test_reset_mid();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
